mem_wb_stage: RTL and testbench

MEM/WB pipeline stage of the RISC-V core. It captures the retiring instruction from the memory stage and, for loads, waits for the data-memory response. It then sign/zero-extends the selected byte, half-word or word. It drives the single register-file write port (we/waddr/wdata) with a one-cycle write pulse per retired instruction.

---
 rtl/mem_wb_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage of the RV32 core.
// Captures the retiring instruction. For loads, it waits for the data-memory
// response, then extracts and extends the addressed byte, half-word or word.
// It drives the register-file write port with one write pulse per retired
// instruction. Loads that are misaligned or use an illegal funct3 are dropped,
// and each one raises a single load_err_o pulse.
//
// Optional feature macro: WB_LOAD_BYPASS_EN
//   When defined, the load response goes to the write port combinationally in
//   the same cycle that dmem_rvalid_i is seen. Non-load writes stay registered.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_load_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic        load_pending_o,
    output logic        load_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,   // ready for the next instruction
        S_WAIT,   // load issued, waiting for its response
        S_DRAIN   // flushed load, swallowing its response
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      state_q, state_d;

    // Context of the outstanding load
    logic        ld_we_q;
    logic [4:0]  ld_waddr_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_lo_q;

    // Registered write port
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic        accept;
    logic        cap_fire;
    logic        ld_fire;
    logic        rsp_fire;
    logic        rsp_we;
    logic        rsp_err;
    logic        ld_bad;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign mem_ready_o    = !rst && (state_q == S_IDLE);
    assign load_pending_o = (state_q != S_IDLE);

    assign accept   = mem_valid_i && mem_ready_o;
    assign cap_fire = accept && !flush_i && !mem_load_i;
    assign ld_fire  = accept && !flush_i && mem_load_i;
    assign rsp_fire = (state_q == S_WAIT) && dmem_rvalid_i && !flush_i;
    assign rsp_we   = rsp_fire && ld_we_q && !ld_bad;
    assign rsp_err  = rsp_fire && ld_bad;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the edge, whatever order
        // the blocks run in.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a flush in WAIT sends the load to DRAIN unless its
    // response arrives in that same cycle
    always_comb begin
        // NOTE: default first, so that no path through the case leaves
        // state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ld_fire) state_d = S_WAIT;
            S_WAIT: begin
                if (dmem_rvalid_i)  state_d = S_IDLE;
                else if (flush_i)   state_d = S_DRAIN;
            end
            S_DRAIN: if (dmem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the context of an accepted load for use when its response arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_we_q     <= 1'b0;
            ld_waddr_q  <= 5'd0;
            ld_funct3_q <= 3'd0;
            ld_lo_q     <= 2'd0;
        end else if (ld_fire) begin
            ld_we_q     <= mem_we_i && (mem_waddr_i != 5'd0);
            ld_waddr_q  <= mem_waddr_i;
            ld_funct3_q <= mem_funct3_i;
            ld_lo_q     <= mem_addr_lo_i;
        end
    end

    // Flag a load that is misaligned or has an illegal funct3
    always_comb begin
        ld_bad = 1'b0;
        unique case (ld_funct3_q)
            F3_LB, F3_LBU: ld_bad = 1'b0;
            F3_LH, F3_LHU: ld_bad = ld_lo_q[0];
            F3_LW:         ld_bad = (ld_lo_q != 2'd0);
            default:       ld_bad = 1'b1;
        endcase
    end

    // Select and sign/zero-extend the addressed part of the little-endian word
    always_comb begin
        ld_byte = dmem_rdata_i[{ld_lo_q, 3'b000} +: 8];
        ld_half = dmem_rdata_i[{ld_lo_q[1], 4'b0000} +: 16];
        ld_data = 32'd0;
        unique case (ld_funct3_q)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            F3_LW:   ld_data = dmem_rdata_i;
            default: ld_data = 32'd0;
        endcase
    end

    // Write-port register: one-cycle pulses for non-loads (and for load
    // responses unless they are bypassed)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            if (cap_fire) begin
                we_q    <= mem_we_i && (mem_waddr_i != 5'd0);
                waddr_q <= mem_waddr_i;
                wdata_q <= mem_wdata_i;
            end
`ifndef WB_LOAD_BYPASS_EN
            else if (rsp_fire) begin
                we_q    <= rsp_we;
                err_q   <= rsp_err;
                waddr_q <= ld_waddr_q;
                wdata_q <= ld_data;
            end
`endif
        end
    end

`ifdef WB_LOAD_BYPASS_EN
    // The load response takes the port in its own cycle. The register is
    // idle then, because the previous edge either accepted the load or
    // waited for it.
    assign we_o       = we_q || rsp_we;
    assign waddr_o    = rsp_fire ? ld_waddr_q : waddr_q;
    assign wdata_o    = rsp_fire ? ld_data : wdata_q;
    assign load_err_o = err_q || rsp_err;
`else
    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign load_err_o = err_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a
// transaction-level reference model (registered-output build).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic        mem_we_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_load_i;
    logic [2:0]  mem_funct3_i;
    logic [1:0]  mem_addr_lo_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        load_pending_o;
    logic        load_err_o;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_we_i       (mem_we_i),
        .mem_waddr_i    (mem_waddr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_load_i     (mem_load_i),
        .mem_funct3_i   (mem_funct3_i),
        .mem_addr_lo_i  (mem_addr_lo_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .we_o           (we_o),
        .waddr_o        (waddr_o),
        .wdata_o        (wdata_o),
        .load_pending_o (load_pending_o),
        .load_err_o     (load_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one outstanding load (possibly killed by a flush)
    // and the write the port should show after the most recent edge.
    bit          m_busy;
    bit          m_killed;
    bit          m_ld_we;
    logic [4:0]  m_ld_rd;
    logic [2:0]  m_ld_f3;
    logic [1:0]  m_ld_lo;
    logic        e_we;
    logic        e_err;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (lo % 2) != 0;
            3'd2:       return lo != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        v = 32'd0;
        case (f3)
            3'd0, 3'd4: begin
                v = (rdata >> (8 * lo)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rdata >> (16 * (lo / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            3'd2:    v = rdata;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_killed = 0; m_ld_we = 0; m_ld_rd = 0; m_ld_f3 = 0; m_ld_lo = 0;
        e_we = 0; e_err = 0; e_waddr = 0; e_wdata = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        e_we  = 0;
        e_err = 0;
        if (!m_busy) begin
            if (mem_valid_i && !flush_i) begin
                if (!mem_load_i) begin
                    e_we    = mem_we_i && (mem_waddr_i != 0);
                    e_waddr = mem_waddr_i;
                    e_wdata = mem_wdata_i;
                end else begin
                    m_busy   = 1;
                    m_killed = 0;
                    m_ld_we  = mem_we_i;
                    m_ld_rd  = mem_waddr_i;
                    m_ld_f3  = mem_funct3_i;
                    m_ld_lo  = mem_addr_lo_i;
                end
            end
        end else if (!m_killed) begin
            if (dmem_rvalid_i) begin
                m_busy = 0;
                if (!flush_i) begin
                    e_err = load_bad(m_ld_f3, m_ld_lo);
                    e_we  = !e_err && m_ld_we && (m_ld_rd != 0);
                    if (e_we) begin
                        e_waddr = m_ld_rd;
                        e_wdata = load_value(m_ld_f3, m_ld_lo, dmem_rdata_i);
                    end
                end
            end else if (flush_i) begin
                m_killed = 1;
            end
        end else if (dmem_rvalid_i) begin
            m_busy   = 0;
            m_killed = 0;
        end
    endtask

    task automatic verify(input string tag);
        check({tag, ".we"},      {31'd0, we_o},           {31'd0, e_we});
        check({tag, ".err"},     {31'd0, load_err_o},     {31'd0, e_err});
        check({tag, ".ready"},   {31'd0, mem_ready_o},    {31'd0, !rst && !m_busy});
        check({tag, ".pending"}, {31'd0, load_pending_o}, {31'd0, m_busy});
        if (e_we) begin
            check({tag, ".waddr"}, {27'd0, waddr_o}, {27'd0, e_waddr});
            check({tag, ".wdata"}, wdata_o, e_wdata);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        verify(tag);
    endtask

    task automatic idle_inputs();
        flush_i = 0; mem_valid_i = 0; mem_we_i = 0; mem_waddr_i = 0; mem_wdata_i = 0;
        mem_load_i = 0; mem_funct3_i = 0; mem_addr_lo_i = 0;
        dmem_rvalid_i = 0; dmem_rdata_i = 0;
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] val, input logic we);
        idle_inputs();
        mem_valid_i = 1; mem_we_i = we; mem_waddr_i = rd; mem_wdata_i = val;
    endtask

    task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        idle_inputs();
        mem_valid_i = 1; mem_we_i = 1; mem_waddr_i = rd; mem_load_i = 1;
        mem_funct3_i = f3; mem_addr_lo_i = lo;
    endtask

    task automatic respond(input logic [31:0] rdata);
        idle_inputs();
        dmem_rvalid_i = 1; dmem_rdata_i = rdata;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        verify("reset");
        check("reset.waddr", {27'd0, waddr_o}, 32'd0);
        check("reset.wdata", wdata_o, 32'd0);
        rst = 0;
        #1;
        verify("reset_release");

        // ADD result to x5: one-cycle write pulse
        send_alu(5'd5, 32'h0000_1234, 1'b1);
        step("add");
        check("add.wdata_const", wdata_o, 32'h0000_1234);
        idle_inputs();
        step("add_after");

        // LB addr_lo=3, response two cycles after accept
        send_load(5'd8, 3'b000, 2'd3);
        step("lb_accept");
        idle_inputs();
        step("lb_wait");
        respond(32'h80FF_FF7F);
        step("lb_resp");
        check("lb.wdata_const", wdata_o, 32'hFFFF_FF80);
        idle_inputs();
        step("lb_after");

        // LHU addr_lo=2
        send_load(5'd9, 3'b101, 2'd2);
        step("lhu_accept");
        respond(32'hBEEF_0000);
        step("lhu_resp");
        check("lhu.wdata_const", wdata_o, 32'h0000_BEEF);

        // Misaligned LW: no write, single err pulse
        send_load(5'd10, 3'b010, 2'd1);
        step("lw_mis_accept");
        respond(32'h1234_5678);
        step("lw_mis_resp");
        check("lw_mis.err_const", {31'd0, load_err_o}, 32'd1);
        idle_inputs();
        step("lw_mis_after");

        // Load to x7 flushed the cycle after accept, response 3 cycles later
        send_load(5'd7, 3'b010, 2'd0);
        step("flush_accept");
        idle_inputs();
        flush_i = 1;
        step("flush_edge");
        idle_inputs();
        step("drain_1");
        step("drain_2");
        respond(32'hDEAD_BEEF);
        step("drain_resp");
        check("drain.ready_const", {31'd0, mem_ready_o}, 32'd1);

        // Write to x0 is suppressed; rvalid in IDLE has no effect
        send_alu(5'd0, 32'hFFFF_FFFF, 1'b1);
        step("x0_write");
        respond(32'hCAFE_F00D);
        step("idle_rvalid");

        // Flush in IDLE discards the transfer
        send_alu(5'd3, 32'h5555_AAAA, 1'b1);
        flush_i = 1;
        step("idle_flush");

        // Back-to-back non-loads
        for (int i = 1; i <= 4; i++) begin
            send_alu(5'(i + 10), 32'(i * 32'h0101_0101), 1'b1);
            step("b2b");
        end

        // Asynchronous reset while a load is outstanding
        send_load(5'd12, 3'b000, 2'd0);
        step("rst_accept");
        rst = 1;
        #1;
        model_reset();
        verify("rst_async");
        check("rst_async.waddr", {27'd0, waddr_o}, 32'd0);
        check("rst_async.wdata", wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        send_alu(5'd13, 32'h0BAD_CAFE, 1'b1);
        step("post_rst_add");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            mem_valid_i   = ($urandom_range(0, 3) != 0);
            mem_we_i      = ($urandom_range(0, 7) != 0);
            mem_waddr_i   = 5'($urandom_range(0, 31));
            mem_wdata_i   = $urandom;
            mem_load_i    = ($urandom_range(0, 1) == 1);
            mem_funct3_i  = 3'($urandom_range(0, 7));
            mem_addr_lo_i = 2'($urandom_range(0, 3));
            dmem_rvalid_i = ($urandom_range(0, 9) < 4);
            dmem_rdata_i  = $urandom;
            flush_i       = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
